// File: rtl/i2c_bit_shifter_if.sv
// Bus-side signal bundle for the I2C receive front end.
// The slave modport is the DUT view; the master modport is the pad/consumer view.
interface i2c_bit_shifter_if;
    logic       scl_in;
    logic       sda_in;
    logic       ack_en;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       bit_tick;
    logic       start_det;
    logic       stop_det;
    logic       busy;
    logic       overrun;

    modport slave (
        input  scl_in, sda_in, ack_en, rx_ready,
        output sda_oe, rx_data, rx_valid, bit_tick, start_det, stop_det, busy, overrun
    );

    modport master (
        output scl_in, sda_in, ack_en, rx_ready,
        input  sda_oe, rx_data, rx_valid, bit_tick, start_det, stop_det, busy, overrun
    );
endinterface

// File: rtl/i2c_bit_shifter.sv
// Oversampled I2C receiver: synchronise and deglitch SCL/SDA, detect START/STOP,
// shift bytes MSB first, drive the ACK bit and hand bytes out on valid/ready.
module i2c_bit_shifter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    i2c_bit_shifter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, ACK_SETUP, ACK_HOLD} state_t;

    localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic [3:0]             scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic                   scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_cond, stop_cond, accepted;

    state_t     state_q, state_d;
    logic [6:0] shreg_q, shreg_d;
    logic [7:0] byte_new;
    logic [7:0] rx_data_q, rx_data_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       ack_ok_q, ack_ok_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rx_valid_q, rx_valid_d;
    logic       overrun_q, overrun_d;
    logic       bit_tick_q, bit_tick_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;

    // Synchroniser shift, then a per-line stability counter: the filtered level
    // follows the synced level only after FILT_LEN consecutive disagreeing cycles.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
        scl_filt_d = scl_filt_q;
        sda_filt_d = sda_filt_q;
        scl_cnt_d  = '0;
        sda_cnt_d  = '0;
        if (scl_sync_q[SYNC_STAGES-1] != scl_filt_q) begin
            if (scl_cnt_q == FILT_LAST) scl_filt_d = scl_sync_q[SYNC_STAGES-1];
            else                        scl_cnt_d  = scl_cnt_q + 4'd1;
        end
        if (sda_sync_q[SYNC_STAGES-1] != sda_filt_q) begin
            if (sda_cnt_q == FILT_LAST) sda_filt_d = sda_sync_q[SYNC_STAGES-1];
            else                        sda_cnt_d  = sda_cnt_q + 4'd1;
        end
        scl_prev_d = scl_filt_q;
        sda_prev_d = sda_filt_q;
    end

    assign scl_rise   =  scl_filt_q & ~scl_prev_q;
    assign scl_fall   = ~scl_filt_q &  scl_prev_q;
    assign sda_rise   =  sda_filt_q & ~sda_prev_q;
    assign sda_fall   = ~sda_filt_q &  sda_prev_q;
    assign start_cond = sda_fall & scl_filt_q;
    assign stop_cond  = sda_rise & scl_filt_q;

    // The 8th bit goes straight into rx_data, so seven stored bits suffice.
    assign byte_new = {shreg_q, sda_filt_q};
    // A consume in the same cycle as the load frees the slot, so the byte is taken.
    assign accepted = !rx_valid_q || bus.rx_ready;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        ack_ok_d    = ack_ok_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        bit_tick_d  = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;

        if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

        if (start_cond) begin
            start_det_d = 1'b1;
            bit_cnt_d   = 4'd0;
            sda_oe_d    = 1'b0;
            state_d     = SHIFT;
        end else if (stop_cond) begin
            stop_det_d = 1'b1;
            sda_oe_d   = 1'b0;
            state_d    = IDLE;
        end else begin
            unique case (state_q)
                SHIFT: begin
                    if (scl_rise) begin
                        bit_tick_d = 1'b1;
                        shreg_d    = byte_new[6:0];
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd8;
                            ack_ok_d  = bus.ack_en && accepted;
                            state_d   = ACK_SETUP;
                            if (accepted) begin
                                rx_data_d  = byte_new;
                                rx_valid_d = 1'b1;
                            end else begin
                                overrun_d  = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ACK_SETUP: begin
                    if (scl_fall) begin
                        sda_oe_d = ack_ok_q;
                        state_d  = ACK_HOLD;
                    end
                end
                ACK_HOLD: begin
                    if (scl_rise) bit_tick_d = 1'b1;
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = SHIFT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_cnt_q   <= '0;
            sda_cnt_q   <= '0;
            scl_filt_q  <= 1'b1;
            sda_filt_q  <= 1'b1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            ack_ok_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            bit_tick_q  <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_cnt_q   <= scl_cnt_d;
            sda_cnt_q   <= sda_cnt_d;
            scl_filt_q  <= scl_filt_d;
            sda_filt_q  <= sda_filt_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            ack_ok_q    <= ack_ok_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            bit_tick_q  <= bit_tick_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.bit_tick  = bit_tick_q;
    assign bus.start_det = start_det_q;
    assign bus.stop_det  = stop_det_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.overrun   = overrun_q;
endmodule
